// File: rtl/fsm_eg_stim_chk_if.sv
// Command bus for the FSM stimulus driver/checker.
// The producer issues {a,b} hold commands. The stimulus block accepts them only while idle.
interface fsm_eg_stim_chk_if #(
   parameter int LEN_W = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_ab;
   logic [LEN_W-1:0] cmd_len;

   modport master (output cmd_valid, cmd_ab, cmd_len, input cmd_ready);
   modport slave  (input cmd_valid, cmd_ab, cmd_len, output cmd_ready);
endinterface

// File: rtl/fsm_eg_stim_chk.sv
// Stimulus driver and checker for the two-input example FSM.
// It drives a,b for max(cmd_len,1) cycles per accepted command.
// It runs its own copy of the FSM and compares x_in/y_in against it on every cycle.
// Optional macro FSM_STIM_SNAP_EN: latch a snapshot of the first mismatch into err_snap.
// Without the macro, err_snap is tied to zero.
module fsm_eg_stim_chk #(
   parameter int            LEN_W = 8,
   parameter int            CNT_W = 16,
   parameter int            DW    = 8,
   parameter logic [DW-1:0] X_VAL = DW'(168),
   parameter logic [DW-1:0] Y_VAL = DW'(168)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fsm_eg_stim_chk_if.slave     cmd,
   input  logic                 chk_en,
   output logic                 a,
   output logic                 b,
   input  logic [DW-1:0]        x_in,
   input  logic [DW-1:0]        y_in,
   output logic                 busy,
   output logic                 done,
   output logic                 err_pulse,
   output logic [CNT_W-1:0]     err_cnt,
   output logic [23:0]          err_snap
);

   typedef enum logic {IDLE, DRIVE} ctl_t;
   typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2} mst_t;

   ctl_t             ctl, ctl_nxt;
   mst_t             ms, ms_nxt;
   logic [LEN_W-1:0] rem, rem_nxt;
   logic             a_nxt, b_nxt, done_nxt;
   logic [DW-1:0]    x_exp, y_exp;
   logic             mis;

   assign cmd.cmd_ready = (ctl == IDLE);
   assign busy          = (ctl == DRIVE);

   // Control state, stimulus and hold counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctl  <= IDLE;
         rem  <= '0;
         a    <= 1'b0;
         b    <= 1'b0;
         done <= 1'b0;
      end else begin
         ctl  <= ctl_nxt;
         rem  <= rem_nxt;
         a    <= a_nxt;
         b    <= b_nxt;
         done <= done_nxt;
      end
   end

   // Command acceptance and hold countdown.
   // A zero length is treated as a single drive cycle.
   always_comb begin
      ctl_nxt  = ctl;
      rem_nxt  = rem;
      a_nxt    = a;
      b_nxt    = b;
      done_nxt = 1'b0;
      case (ctl)
         IDLE: begin
            a_nxt = 1'b0;
            b_nxt = 1'b0;
            if (cmd.cmd_valid) begin
               ctl_nxt = DRIVE;
               a_nxt   = cmd.cmd_ab[1];
               b_nxt   = cmd.cmd_ab[0];
               rem_nxt = (cmd.cmd_len == '0) ? '0 : cmd.cmd_len - 1'b1;
            end
         end
         DRIVE: begin
            if (rem != '0) begin
               rem_nxt = rem - 1'b1;
            end else begin
               a_nxt    = 1'b0;
               b_nxt    = 1'b0;
               done_nxt = 1'b1;
               ctl_nxt  = IDLE;
            end
         end
         default: ctl_nxt = IDLE;
      endcase
   end

   // Reference FSM state register; it tracks the driven a,b every cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ms <= S0;
      else        ms <= ms_nxt;
   end

   // Reference FSM next state and expected (Mealy) outputs
   always_comb begin
      ms_nxt = S0;
      x_exp  = '0;
      y_exp  = '0;
      case (ms)
         S0: begin
            if (a && b) begin
               x_exp  = X_VAL;
               ms_nxt = S2;
            end else if (a && !b) begin
               ms_nxt = S1;
            end
         end
         S1: begin
            y_exp  = Y_VAL;
            ms_nxt = a ? S0 : S1;
         end
         S2: begin
            if (a && b) x_exp = X_VAL;
         end
         default: ms_nxt = S0;
      endcase
   end

   assign mis = chk_en & ((x_in != x_exp) | (y_in != y_exp));

   // Mismatch pulse and saturating mismatch counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_pulse <= 1'b0;
         err_cnt   <= '0;
      end else begin
         err_pulse <= mis;
         if (mis && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
      end
   end

`ifdef FSM_STIM_SNAP_EN
   localparam int XW = (DW > 8) ? DW : 8;
   logic [XW-1:0] x_ext, y_ext;
   logic          snap_vld;

   assign x_ext = XW'(x_in);
   assign y_ext = XW'(y_in);

   // First-mismatch snapshot; held until the next reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_snap <= '0;
         snap_vld <= 1'b0;
      end else if (mis && !snap_vld) begin
         err_snap <= {ms, a, b, 4'b0, x_ext[7:0], y_ext[7:0]};
         snap_vld <= 1'b1;
      end
   end
`else
   assign err_snap = '0;
`endif

endmodule

// File: tb/tb_fsm_eg_stim_chk.sv
// Bench for fsm_eg_stim_chk. A table-driven FSM stands in for the device under test.
// Faults are injected into x_in/y_in by XOR masks.
// A queue-based schedule predicts a,b,busy,done and the error outputs.
module tb_fsm_eg_stim_chk;
   localparam int LEN_W = 8;
   localparam int CNT_W = 2;
   localparam int DW    = 8;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             chk_en = 1'b0;
   logic             a, b, busy, done, err_pulse;
   logic [CNT_W-1:0] err_cnt;
   logic [23:0]      err_snap;
   logic [DW-1:0]    x_in, y_in;
   logic [DW-1:0]    xm = '0, ym = '0;

   fsm_eg_stim_chk_if #(.LEN_W(LEN_W)) cif();

   fsm_eg_stim_chk #(.LEN_W(LEN_W), .CNT_W(CNT_W), .DW(DW), .X_VAL(8'd168), .Y_VAL(8'd168)) dut (
      .clk(clk), .rst_n(rst_n), .cmd(cif), .chk_en(chk_en), .a(a), .b(b),
      .x_in(x_in), .y_in(y_in), .busy(busy), .done(done), .err_pulse(err_pulse),
      .err_cnt(err_cnt), .err_snap(err_snap)
   );

   always #5 clk = ~clk;

   // Example FSM as lookup tables: row = state (0=S0,1=S1,2=S2), column = {a,b}
   int nxt_tab [0:2][0:3] = '{'{0, 0, 1, 2}, '{1, 1, 0, 0}, '{0, 0, 0, 0}};
   bit x_on    [0:2][0:3] = '{'{0, 0, 0, 1}, '{0, 0, 0, 0}, '{0, 0, 0, 1}};
   int st;

   // Emulated device state; it follows the stimulus that the checker drives
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= 0;
      else        st <= nxt_tab[st][{a, b}];
   end

   assign x_in = (x_on[st][{a, b}] ? 8'd168 : 8'd0) ^ xm;
   assign y_in = ((st == 1) ? 8'd168 : 8'd0) ^ ym;

   typedef struct packed {logic busy; logic a; logic b; logic done;} ent_t;
   ent_t        sched[$];
   int          m_cnt;
   bit          m_ep, m_snapped;
   logic [23:0] m_snap;
   int          checks = 0, errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Check this cycle's outputs against the schedule.
   // Then apply the new inputs and predict the effect of the coming edge.
   task automatic step(input bit v, input bit [1:0] ab, input bit [7:0] len, input bit ce,
                       input bit [7:0] xmk, input bit [7:0] ymk);
      ent_t e;
      bit   mis;
      @(negedge clk);
      if (sched.size() > 0) e = sched.pop_front();
      else                  e = '0;
      chk("a", 32'(a), 32'(e.a));
      chk("b", 32'(b), 32'(e.b));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("done", 32'(done), 32'(e.done));
      chk("cmd_ready", 32'(cif.cmd_ready), 32'(!e.busy));
      chk("err_pulse", 32'(err_pulse), 32'(m_ep));
      chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
`ifdef FSM_STIM_SNAP_EN
      chk("err_snap", 32'(err_snap), 32'(m_snap));
`else
      chk("err_snap", 32'(err_snap), 32'd0);
`endif
      cif.cmd_valid = v; cif.cmd_ab = ab; cif.cmd_len = len;
      chk_en = ce; xm = xmk; ym = ymk;
      #1;
      mis = ce && (xmk != 8'd0 || ymk != 8'd0);
      if (mis && !m_snapped) begin
         m_snapped = 1'b1;
         m_snap    = {2'(st), a, b, 4'b0, x_in, y_in};
      end
      m_ep = mis;
      if (mis && m_cnt < CMAX) m_cnt++;
      if (v && !e.busy) begin
         for (int i = 0; i < ((len == 8'd0) ? 1 : int'(len)); i++)
            sched.push_back('{busy: 1'b1, a: ab[1], b: ab[0], done: 1'b0});
         sched.push_back('{busy: 1'b0, a: 1'b0, b: 1'b0, done: 1'b1});
      end
   endtask

   // Asynchronous reset, asserted away from any clock edge.
   // The reset values are checked at once.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_a", 32'(a), 32'd0);
      chk("rst_b", 32'(b), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err_pulse", 32'(err_pulse), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      chk("rst_err_snap", 32'(err_snap), 32'd0);
      chk("rst_cmd_ready", 32'(cif.cmd_ready), 32'd1);
      sched.delete();
      m_cnt = 0; m_ep = 1'b0; m_snapped = 1'b0; m_snap = '0;
      cif.cmd_valid = 1'b0; chk_en = 1'b0; xm = '0; ym = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit v; bit [1:0] ab; bit [7:0] len; bit ce; bit [7:0] xmk, ymk;
      bit ea, eb, ebusy, edone, eep; int ecnt;
   } vec_t;
   vec_t tbl [0:22];

   initial begin
      // inputs for the cycle, then the outputs expected in that same cycle
      tbl[0]  = '{1'b1, 2'b11, 8'd1, 1'b1, 8'd0,   8'd0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      tbl[1]  = '{1'b0, 2'b00, 8'd0, 1'b1, 8'd0,   8'd0,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
      tbl[2]  = '{1'b0, 2'b00, 8'd0, 1'b1, 8'd0,   8'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
      tbl[3]  = '{1'b1, 2'b10, 8'd3, 1'b1, 8'd0,   8'd0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      tbl[4]  = '{1'b0, 2'b00, 8'd0, 1'b1, 8'd0,   8'd0,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
      tbl[5]  = '{1'b0, 2'b00, 8'd0, 1'b1, 8'd0,   8'd0,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
      tbl[6]  = '{1'b0, 2'b00, 8'd0, 1'b1, 8'd0,   8'd0,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
      tbl[7]  = '{1'b0, 2'b00, 8'd0, 1'b1, 8'd0,   8'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
      tbl[8]  = '{1'b1, 2'b11, 8'd1, 1'b1, 8'd0,   8'd0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
      tbl[9]  = '{1'b0, 2'b00, 8'd0, 1'b1, 8'd0,   8'd0,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
      tbl[10] = '{1'b1, 2'b11, 8'd1, 1'b1, 8'd0,   8'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
      tbl[11] = '{1'b0, 2'b00, 8'd0, 1'b1, 8'd168, 8'd0,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
      tbl[12] = '{1'b0, 2'b00, 8'd0, 1'b1, 8'd0,   8'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1};
      tbl[13] = '{1'b0, 2'b00, 8'd0, 1'b1, 8'd0,   8'hFF,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
      tbl[14] = '{1'b0, 2'b00, 8'd0, 1'b1, 8'd0,   8'hFF,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2};
      tbl[15] = '{1'b0, 2'b00, 8'd0, 1'b1, 8'd0,   8'hFF,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3};
      tbl[16] = '{1'b0, 2'b00, 8'd0, 1'b1, 8'd0,   8'hFF,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3};
      tbl[17] = '{1'b0, 2'b00, 8'd0, 1'b1, 8'd0,   8'hFF,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3};
      tbl[18] = '{1'b0, 2'b00, 8'd0, 1'b1, 8'd0,   8'd0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3};
      tbl[19] = '{1'b1, 2'b01, 8'd0, 1'b1, 8'd0,   8'd0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3};
      tbl[20] = '{1'b1, 2'b11, 8'd5, 1'b1, 8'd0,   8'd0,    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3};
      tbl[21] = '{1'b0, 2'b00, 8'd0, 1'b1, 8'd0,   8'd0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3};
      tbl[22] = '{1'b0, 2'b00, 8'd0, 1'b1, 8'd0,   8'd0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3};

      cif.cmd_valid = 1'b0; cif.cmd_ab = 2'b00; cif.cmd_len = '0;
      m_cnt = 0; m_ep = 1'b0; m_snapped = 1'b0; m_snap = '0;
      #1;
      do_reset();

      // Basic drives, back-to-back commands, injected mismatch, saturation, zero length
      for (int i = 0; i <= 22; i++) begin
         step(tbl[i].v, tbl[i].ab, tbl[i].len, tbl[i].ce, tbl[i].xmk, tbl[i].ymk);
         chk($sformatf("tbl%0d_a", i), 32'(a), 32'(tbl[i].ea));
         chk($sformatf("tbl%0d_b", i), 32'(b), 32'(tbl[i].eb));
         chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].ebusy));
         chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].edone));
         chk($sformatf("tbl%0d_err_pulse", i), 32'(err_pulse), 32'(tbl[i].eep));
         chk($sformatf("tbl%0d_err_cnt", i), 32'(err_cnt), 32'(tbl[i].ecnt));
      end
`ifdef FSM_STIM_SNAP_EN
      chk("snap_first_mis", 32'(err_snap), 32'h300000);
`endif

      // Long command aborted by reset in its 50th drive cycle; no done afterwards
      step(1'b1, 2'b10, 8'd200, 1'b1, 8'd0, 8'd0);
      repeat (50) step(1'b0, 2'b00, 8'd0, 1'b1, 8'd0, 8'd0);
      chk("abort_busy_before", 32'(busy), 32'd1);
      #2;
      do_reset();
      repeat (4) step(1'b0, 2'b00, 8'd0, 1'b1, 8'd0, 8'd0);
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_ready", 32'(cif.cmd_ready), 32'd1);

      // Random commands, checking gaps and occasional faults, with rare resets
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 249) == 0) begin
            #2;
            do_reset();
         end else begin
            step(1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom_range(0, 5)),
                 $urandom_range(0, 9) != 0,
                 ($urandom_range(0, 24) == 0) ? 8'($urandom) : 8'd0,
                 ($urandom_range(0, 24) == 0) ? 8'($urandom) : 8'd0);
         end
      end
      step(1'b0, 2'b00, 8'd0, 1'b0, 8'd0, 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
